// File: rtl/calc_pkg.sv
// Shared command codes and FSM state type for the calculator front end and core.
package calc_pkg;

  localparam int CMD_W    = 3;
  localparam int NUM_KEYS = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE   = 3'd0,
    CMD_CLEAR  = 3'd1,
    CMD_RESULT = 3'd2,
    CMD_ADD    = 3'd3,
    CMD_SUB    = 3'd4,
    CMD_MULT   = 3'd5,
    CMD_DIV    = 3'd6
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Command issued by a press of key_idx; control mode only uses KEY0 and KEY3.
  function automatic cmd_e key_to_cmd(input logic [1:0] key_idx, input logic ctrl_mode);
    cmd_e c;
    c = CMD_NONE;
    if (ctrl_mode) begin
      case (key_idx)
        2'd0:    c = CMD_CLEAR;
        2'd3:    c = CMD_RESULT;
        default: c = CMD_NONE;
      endcase
    end else begin
      case (key_idx)
        2'd0:    c = CMD_DIV;
        2'd1:    c = CMD_MULT;
        2'd2:    c = CMD_SUB;
        default: c = CMD_ADD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, accepted level
// and a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             raw_pressed;

  assign raw_pressed = ~sync2_q;
  assign pressed_o   = level_q;
  assign press_o     = press_q;

  // Synchronise the raw pin; resets to released (high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing cycles; flip the accepted level on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (raw_pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = raw_pressed;
      press_d = raw_pressed;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/key_cmd_issuer.sv
// Turns debounced key presses into single-entry valid/ready calculator commands.
module key_cmd_issuer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int W               = 11
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic             mode,
  input  logic [W-1:0]     operand_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd,
  output logic [W-1:0]     operand,
  output logic [3:0]       key_pressed,
  output logic             overrun
);

  logic         mode_s1_q, mode_s_q;
  logic [W-1:0] opnd_s1_q, opnd_s_q;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] level;

  cmd_e   sel_cmd, cand_cmd;
  logic   new_vld, drop_multi;

  state_e       state_q;
  logic         cmd_valid_q;
  cmd_e         cmd_q;
  logic [W-1:0] operand_q;
  logic         overrun_q;

  // Synchronise mode and operand switches.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mode_s1_q <= 1'b0;
      mode_s_q  <= 1'b0;
      opnd_s1_q <= '0;
      opnd_s_q  <= '0;
    end else begin
      mode_s1_q <= mode;
      mode_s_q  <= mode_s1_q;
      opnd_s1_q <= operand_in;
      opnd_s_q  <= opnd_s1_q;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i    (CLOCK_50),
      .rst_i    (reset),
      .key_n_i  (KEY[g]),
      .pressed_o(level[g]),
      .press_o  (press[g])
    );
  end

  // Lowest-index press that maps to a command wins; other command presses are dropped.
  always_comb begin
    sel_cmd    = CMD_NONE;
    cand_cmd   = CMD_NONE;
    new_vld    = 1'b0;
    drop_multi = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      cand_cmd = key_to_cmd(2'(k), mode_s_q);
      if (press[k] && (cand_cmd != CMD_NONE)) begin
        if (!new_vld) begin
          new_vld = 1'b1;
          sel_cmd = cand_cmd;
        end else begin
          drop_multi = 1'b1;
        end
      end
    end
  end

  // Single-entry command holder: IDLE/PEND handshake FSM with sticky overrun.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
      operand_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (drop_multi) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (new_vld) begin
            state_q     <= ST_PEND;
            cmd_valid_q <= 1'b1;
            cmd_q       <= sel_cmd;
            operand_q   <= opnd_s_q;
          end
        end
        ST_PEND: begin
          if (cmd_ready) begin
            // Transfer and a fresh press in one cycle: reload and stay pending.
            if (new_vld) begin
              cmd_q     <= sel_cmd;
              operand_q <= opnd_s_q;
            end else begin
              state_q     <= ST_IDLE;
              cmd_valid_q <= 1'b0;
            end
          end else if (new_vld) begin
            overrun_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign operand     = operand_q;
  assign key_pressed = level;
  assign overrun     = overrun_q;

endmodule

// File: doc/key_cmd_issuer.md
# key_cmd_issuer

Front end of the sequential calculator that turns the four raw push-buttons and the mode switch into clean, one-at-a-time operation commands for the four-function calculator core. It synchronises and debounces each active-low KEY and detects press edges. It maps each press to a command code according to the mode switch (SW[17]), captures the operand switches at that moment, and hands the command to the core over a single-entry valid/ready handshake. The block sits between the board pins and the calculator core, replacing the ad-hoc combinational key decoding at top level.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key level is accepted (10 ms at 50 MHz); minimum 2
- W, 11, operand width

- CLOCK_50  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- KEY  in  4  raw push-buttons, active-low, asynchronous
- mode  in  1  SW[17], asynchronous; 1 = control mode, 0 = arithmetic mode
- operand_in  in  W  SW[W-1:0], asynchronous, quasi-static
- cmd_ready  in  1  core accepts command
- cmd_valid  out  1  command pending
- cmd  out  3  command code (package)
- operand  out  W  operand captured with the command
- key_pressed  out  4  debounced level, 1 = pressed
- overrun  out  1  sticky: a press was discarded

## Operation
- KEY, mode and operand_in each pass through a 2-flop synchroniser. KEY syncs reset to 1 (released).
- Per-key debounce: counter clears whenever the synced level equals the accepted level. Otherwise it increments. When the count reaches DEBOUNCE_CYCLES-1 on a differing cycle, the accepted level flips and the counter clears. Any bounce back restarts the count.
- Press edge: accepted level goes from released to pressed. Release edges generate nothing.
- Mapping, using the synced mode at the edge cycle:
  - mode=1: KEY0 issues CLEAR; KEY3 issues RESULT; KEY1 and KEY2 are ignored (no command, no overrun).
  - mode=0: KEY3 issues ADD, KEY2 issues SUB, KEY1 issues MULT, KEY0 issues DIV.
- Several press edges in the same cycle: the lowest KEY index producing a command wins. The others are discarded and overrun is set.
- FSM IDLE/PEND:
  - IDLE plus a command edge: load cmd and operand (synced operand_in), assert cmd_valid, go to PEND.
  - PEND: cmd and operand are held stable. cmd_valid&&cmd_ready completes the transfer and returns to IDLE.
  - PEND plus a new command edge without a transfer in the same cycle: the new press is dropped, overrun is set, and the pending command is unchanged.
  - PEND with a transfer and a new edge in the same cycle: the new command loads and the FSM stays in PEND. Nothing is dropped.
- overrun clears only on reset.
- Reset values: cmd_valid=0, cmd=NONE, operand=0, key_pressed=0, overrun=0, FSM=IDLE, counters=0, accepted levels=released. A key held through reset release issues its command after a full debounce.

## Timing
- A synced level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle. key_pressed updates on that edge.
- cmd_valid rises on the clock edge after the accepted-level change, giving 1 cycle of edge-detect/register latency.
- Raw pin to cmd_valid is DEBOUNCE_CYCLES+3 cycles nominal (2 sync + debounce + 1).
- With cmd_ready held high, cmd_valid is high for exactly 1 cycle per press.
- Back-to-back transfers: one command per cycle maximum. This is unreachable in practice given the debounce.
- Reset is asynchronous assert; release is synchronised externally. Reset mid-PEND drops the pending command with no partial transfer.

## Structure
- Shared package calc_pkg:
  - CMD_W=3
  - codes NONE=0, CLEAR=1, RESULT=2, ADD=3, SUB=4, MULT=5, DIV=6
  - FSM state enum
- The core consumes the same package.
- Sub-module key_debounce (sync + counter + accepted level + press pulse), instantiated 4 times.
- Counter width: $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- mode=0, operand_in=25, cmd_ready=1, KEY[3] low for 12 cycles -> exactly one ADD with operand=25, 1-cycle cmd_valid, 7 cycles after the KEY fall; nothing on release.
- KEY[2] toggles every 2 cycles for 16 cycles, then stays low -> no command during the bounce; a single SUB 4 accepted cycles after the final fall.
- mode=1: KEY0 press -> CLEAR; KEY1 press -> no command and overrun stays 0; KEY3 press -> RESULT.
- cmd_ready=0: press KEY1 (MULT, operand=7), then KEY0 with operand=3 -> cmd stays MULT/7 and overrun=1. Then cmd_ready=1 -> one transfer, cmd_valid low the next cycle.
- mode=0: KEY0 and KEY3 fall in the same cycle -> DIV only, overrun=1.
- reset pulsed while PEND -> cmd_valid=0, cmd=NONE and overrun=0 immediately. With KEY[3] held low through reset release -> ADD issued after debounce.
